// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: SRAM pass converting interleaved RGB into BT.601 Y, U, V planes (U/V halved horizontally), 20 cycles per 4-pixel group.
// Build option UV_AVERAGE_EN: U/V come from the rounded average of each pixel pair instead of the even pixel.
module rgb_to_yuv_encoder #(
   parameter logic [17:0] Y_BASE      = 18'd0,
   parameter logic [17:0] U_BASE      = 18'd38400,
   parameter logic [17:0] V_BASE      = 18'd57600,
   parameter logic [17:0] RGB_BASE    = 18'd146944,
   parameter logic [16:0] GROUP_COUNT = 17'd19200
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        Done
);

   typedef enum logic [4:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RD_W0, S_RD_W1,
      S_CALC, S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
   } state_t;

   state_t state, state_n;
   logic [16:0] grp, grp_n;
   logic [2:0]  sub, sub_n;
   logic [17:0] addr_n;
   logic [15:0] wdata_n;
   logic        we_n_n, done_n;

   logic [5:0][15:0] word;
   logic [7:0][7:0]  res;
   logic [3:0][7:0]  pr, pg, pb;
   logic [17:0]      g18, g18_inc;

   logic [7:0]         op_r, op_g, op_b;
   logic signed [31:0] c_r, c_g, c_b, ofs, sum, shifted;
   logic [7:0]         res_val;

   assign g18     = {1'b0, grp};
   assign g18_inc = g18 + 18'd1;

   // Six words carry four pixels as a byte stream R,G,B,R,G,B,... upper byte first
   assign pr[0] = word[0][15:8];  assign pg[0] = word[0][7:0];   assign pb[0] = word[1][15:8];
   assign pr[1] = word[1][7:0];   assign pg[1] = word[2][15:8];  assign pb[1] = word[2][7:0];
   assign pr[2] = word[3][15:8];  assign pg[2] = word[3][7:0];   assign pb[2] = word[4][15:8];
   assign pr[3] = word[4][7:0];   assign pg[3] = word[5][15:8];  assign pb[3] = word[5][7:0];

   function automatic logic [17:0] rgb_addr(input logic [17:0] g);
      return RGB_BASE + (g << 2) + (g << 1);
   endfunction

   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + 9'd1;
      return s[8:1];
   endfunction

   // sub 0..3: Y of pixel sub; 4,5: U of pair 0/1; 6,7: V of pair 0/1
   always_comb begin
      op_r = pr[sub[1:0]];
      op_g = pg[sub[1:0]];
      op_b = pb[sub[1:0]];
      c_r  = 32'sd16843;
      c_g  = 32'sd33030;
      c_b  = 32'sd6423;
      ofs  = 32'sd1081344;
      if (sub[2]) begin
`ifdef UV_AVERAGE_EN
         op_r = avg8(pr[{sub[0], 1'b0}], pr[{sub[0], 1'b1}]);
         op_g = avg8(pg[{sub[0], 1'b0}], pg[{sub[0], 1'b1}]);
         op_b = avg8(pb[{sub[0], 1'b0}], pb[{sub[0], 1'b1}]);
`else
         op_r = pr[{sub[0], 1'b0}];
         op_g = pg[{sub[0], 1'b0}];
         op_b = pb[{sub[0], 1'b0}];
`endif
         ofs = 32'sd8421376;
         if (!sub[1]) begin
            c_r = -32'sd9699;
            c_g = -32'sd19071;
            c_b = 32'sd28770;
         end else begin
            c_r = 32'sd28770;
            c_g = -32'sd24117;
            c_b = -32'sd4653;
         end
      end
      sum     = c_r * $signed({24'd0, op_r}) + c_g * $signed({24'd0, op_g})
              + c_b * $signed({24'd0, op_b}) + ofs;
      shifted = sum >>> 16;
      if (sum[31])
         res_val = 8'd0;
      else if (shifted > 32'sd255)
         res_val = 8'd255;
      else
         res_val = shifted[7:0];
   end

   always_comb begin
      state_n = state;
      grp_n   = grp;
      sub_n   = sub;
      addr_n  = SRAM_address;
      wdata_n = SRAM_write_data;
      we_n_n  = 1'b1;
      done_n  = 1'b0;
      case (state)
         S_IDLE: if (Enable) begin
            state_n = S_RD0;
            addr_n  = rgb_addr(g18);
         end
         S_RD0: begin state_n = S_RD1; addr_n = SRAM_address + 18'd1; end
         S_RD1: begin state_n = S_RD2; addr_n = SRAM_address + 18'd1; end
         S_RD2: begin state_n = S_RD3; addr_n = SRAM_address + 18'd1; end
         S_RD3: begin state_n = S_RD4; addr_n = SRAM_address + 18'd1; end
         S_RD4: begin state_n = S_RD5; addr_n = SRAM_address + 18'd1; end
         S_RD5:   state_n = S_RD_W0;
         S_RD_W0: state_n = S_RD_W1;
         S_RD_W1: begin state_n = S_CALC; sub_n = 3'd0; end
         S_CALC: begin
            sub_n = sub + 3'd1;
            if (sub == 3'd7) begin
               state_n = S_WR_Y0;
               addr_n  = Y_BASE + (g18 << 1);
               wdata_n = {res[0], res[1]};
               we_n_n  = 1'b0;
            end
         end
         S_WR_Y0: begin
            state_n = S_WR_Y1;
            addr_n  = SRAM_address + 18'd1;
            wdata_n = {res[2], res[3]};
            we_n_n  = 1'b0;
         end
         S_WR_Y1: begin
            state_n = S_WR_U;
            addr_n  = U_BASE + g18;
            wdata_n = {res[4], res[5]};
            we_n_n  = 1'b0;
         end
         S_WR_U: begin
            state_n = S_WR_V;
            addr_n  = V_BASE + g18;
            wdata_n = {res[6], res[7]};
            we_n_n  = 1'b0;
         end
         S_WR_V: begin
            if (grp == GROUP_COUNT - 17'd1) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else begin
               grp_n   = grp + 17'd1;
               state_n = S_RD0;
               addr_n  = rgb_addr(g18_inc);
            end
         end
         S_DONE: begin
            grp_n   = 17'd0;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state           <= S_IDLE;
         grp             <= 17'd0;
         sub             <= 3'd0;
         SRAM_address    <= 18'd0;
         SRAM_write_data <= 16'd0;
         SRAM_we_n       <= 1'b1;
         Done            <= 1'b0;
      end else begin
         state           <= state_n;
         grp             <= grp_n;
         sub             <= sub_n;
         SRAM_address    <= addr_n;
         SRAM_write_data <= wdata_n;
         SRAM_we_n       <= we_n_n;
         Done            <= done_n;
      end
   end

   // Read data returns two cycles after its address, hence capture in S_RD2..S_RD_W1
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         word <= '0;
         res  <= '0;
      end else begin
         case (state)
            S_RD2:   word[0]  <= SRAM_read_data;
            S_RD3:   word[1]  <= SRAM_read_data;
            S_RD4:   word[2]  <= SRAM_read_data;
            S_RD5:   word[3]  <= SRAM_read_data;
            S_RD_W0: word[4]  <= SRAM_read_data;
            S_RD_W1: word[5]  <= SRAM_read_data;
            S_CALC:  res[sub] <= res_val;
            default: ;
         endcase
      end
   end

endmodule
